// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard/sequencing controller: state encoding,
// register address width and the enable/flush bundle driven into the pipeline.
package pipeline_pkg;

  localparam int REG_ADDR_W = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_FREEZE = '0;
  localparam ctrl_bundle_t CTRL_ADVANCE = '{
    pc_we: 1'b1, if_id_we: 1'b1, id_ex_we: 1'b1, ex_mem_we: 1'b1,
    mem_wb_we: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0
  };

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detection from the ID-stage sources and the ID/EX destination.
// Purely combinational so the forwarding unit can share it.
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int R0_IS_ZERO = 1
) (
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_mem_read,
  output logic                  loaduse
);

  logic rs1_match;
  logic rs2_match;
  logic rd_is_r0;

  assign rs1_match = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
  assign rs2_match = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
  // r0 is hardwired, so a load targeting it never produces a value to wait for
  assign rd_is_r0  = (R0_IS_ZERO != 0) && (ex_rd_addr == '0);

  assign loaduse = ex_mem_read && (rs1_match || rs2_match) && !rd_is_r0;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stage write
// enables, bubble requests, memory-wait timeout and HALT drain.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// ST_RUN    | normal issue; memwait > branch > loaduse > halt > advance
// ST_DRAIN  | HALT in flight; only bubbles enter ID/EX until retired
// ST_HALTED | stopped after HALT retire or memory timeout; exit by reset
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int STALL_CNT_W  = 16,
  parameter int MEM_TIMEOUT  = 64,
  parameter int DRAIN_CYCLES = 3,
  parameter int R0_IS_ZERO   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_ADDR_W-1:0]  id_rs1_addr,
  input  logic [REG_ADDR_W-1:0]  id_rs2_addr,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic                   id_halt,
  input  logic [REG_ADDR_W-1:0]  ex_rd_addr,
  input  logic                   ex_mem_read,
  input  logic                   ex_branch_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_we,
  output logic                   if_id_we,
  output logic                   id_ex_we,
  output logic                   ex_mem_we,
  output logic                   mem_wb_we,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   halted,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LOAD  = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  state_t             state, state_next;
  ctrl_bundle_t       ctrl;
  logic               memwait;
  logic               loaduse;
  logic               timeout_hit;
  logic               stall_inc;
  logic [WAIT_W-1:0]  wait_left;
  logic [DRAIN_W-1:0] drain_left;

  hazard_detect #(
    .R0_IS_ZERO (R0_IS_ZERO)
  ) u_hazard_detect (
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd_addr  (ex_rd_addr),
    .ex_mem_read (ex_mem_read),
    .loaduse     (loaduse)
  );

  assign memwait = mem_req && !mem_ready;

  always_comb begin
    ctrl        = CTRL_FREEZE;
    state_next  = state;
    timeout_hit = 1'b0;
    if (!reset) begin
      case (state)
        ST_RUN: begin
          if (memwait) begin
            ctrl = CTRL_FREEZE;
            if (wait_left == '0) begin
              timeout_hit = 1'b1;
              state_next  = ST_HALTED;
            end
          end else if (ex_branch_taken) begin
            ctrl             = CTRL_ADVANCE;
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
          end else if (loaduse) begin
            ctrl             = CTRL_ADVANCE;
            ctrl.pc_we       = 1'b0;
            ctrl.if_id_we    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
          end else if (id_halt) begin
            // HALT moves into ID/EX; fetch stops and a bubble follows it
            ctrl             = CTRL_ADVANCE;
            ctrl.pc_we       = 1'b0;
            ctrl.if_id_flush = 1'b1;
            state_next       = ST_DRAIN;
          end else begin
            ctrl = CTRL_ADVANCE;
          end
        end
        ST_DRAIN: begin
          if (memwait) begin
            ctrl = CTRL_FREEZE;
            if (wait_left == '0) begin
              timeout_hit = 1'b1;
              state_next  = ST_HALTED;
            end
          end else begin
            ctrl             = CTRL_ADVANCE;
            ctrl.pc_we       = 1'b0;
            ctrl.if_id_we    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
            if (drain_left == '0) begin
              state_next = ST_HALTED;
            end
          end
        end
        ST_HALTED: begin
          ctrl = CTRL_FREEZE;
        end
        default: begin
          ctrl       = CTRL_FREEZE;
          state_next = ST_RUN;
        end
      endcase
    end
  end

  assign pc_we       = ctrl.pc_we;
  assign if_id_we    = ctrl.if_id_we;
  assign id_ex_we    = ctrl.id_ex_we;
  assign ex_mem_we   = ctrl.ex_mem_we;
  assign mem_wb_we   = ctrl.mem_wb_we;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;

  // The cycle that lands in HALTED is not a stall cycle
  assign stall_inc = (state != ST_HALTED) && !ctrl.pc_we &&
                     (state_next != ST_HALTED) && (stall_count != '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      wait_left   <= WAIT_LOAD;
      drain_left  <= DRAIN_LOAD;
      mem_timeout <= 1'b0;
      halted      <= 1'b0;
      stall_count <= '0;
    end else begin
      state       <= state_next;
      mem_timeout <= mem_timeout | timeout_hit;
      halted      <= (state_next == ST_HALTED);

      if (memwait && wait_left != '0) begin
        wait_left <= wait_left - WAIT_W'(1);
      end else if (!memwait) begin
        wait_left <= WAIT_LOAD;
      end

      if (state != ST_DRAIN) begin
        drain_left <= DRAIN_LOAD;
      end else if (!memwait && drain_left != '0) begin
        drain_left <= drain_left - DRAIN_W'(1);
      end

      if (stall_inc) begin
        stall_count <= stall_count + STALL_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a vector table for the RUN-state priority
// logic plus hand-written memory-wait, timeout and HALT drain sequences.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_uses_rs1, id_uses_rs2, id_halt;
  logic        ex_mem_read, ex_branch_taken, mem_req, mem_ready;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic        if_id_flush, id_ex_flush, halted, mem_timeout;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;
  int stall_exp = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .STALL_CNT_W (16),
    .MEM_TIMEOUT (64),
    .DRAIN_CYCLES(3),
    .R0_IS_ZERO  (1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_halt         (id_halt),
    .ex_rd_addr      (ex_rd_addr),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_we           (pc_we),
    .if_id_we        (if_id_we),
    .id_ex_we        (id_ex_we),
    .ex_mem_we       (ex_mem_we),
    .mem_wb_we       (mem_wb_we),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .halted          (halted),
    .mem_timeout     (mem_timeout),
    .stall_count     (stall_count)
  );

  // {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush}
  localparam logic [6:0] C_ALL   = 7'b11111_00;
  localparam logic [6:0] C_FRZ   = 7'b00000_00;
  localparam logic [6:0] C_LU    = 7'b00111_01;
  localparam logic [6:0] C_BR    = 7'b11111_11;
  localparam logic [6:0] C_HALT  = 7'b01111_10;
  localparam logic [6:0] C_DRAIN = 7'b00111_01;

  typedef struct {
    string      name;
    logic [2:0] rs1, rs2, rd;
    logic       u1, u2, mrd, br, mreq, mrdy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [6:0] ctrl_now();
    return {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs1_addr = 3'd0; id_rs2_addr = 3'd0; ex_rd_addr = 3'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_halt = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    stall_exp = 0;
  endtask

  initial begin
    vecs[0]  = '{"idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, C_ALL};
    vecs[1]  = '{"lu_rs2_r3",     0, 3, 3, 0, 1, 1, 0, 0, 0, C_LU};
    vecs[2]  = '{"after_bubble",  0, 3, 3, 0, 1, 0, 0, 0, 0, C_ALL};
    vecs[3]  = '{"lu_r0_ignored", 0, 0, 0, 0, 1, 1, 0, 0, 0, C_ALL};
    vecs[4]  = '{"br_over_lu",    0, 3, 3, 0, 1, 1, 1, 0, 0, C_BR};
    vecs[5]  = '{"memwait",       0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ};
    vecs[6]  = '{"mem_ready",     0, 0, 0, 0, 0, 0, 0, 1, 1, C_ALL};
    vecs[7]  = '{"lu_rs1_r5",     5, 1, 5, 1, 0, 1, 0, 0, 0, C_LU};
    vecs[8]  = '{"rs1_unused",    5, 1, 5, 0, 0, 1, 0, 0, 0, C_ALL};
    vecs[9]  = '{"no_mem_read",   5, 5, 5, 1, 1, 0, 0, 0, 0, C_ALL};
    vecs[10] = '{"memwait_br",    0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ};
    vecs[11] = '{"memwait_lu",    0, 3, 3, 0, 1, 1, 0, 1, 0, C_FRZ};

    // reset state
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    chk("reset_ctrl", 32'(ctrl_now()), 32'(C_FRZ));
    chk("reset_halted", 32'(halted), 0);
    chk("reset_stall", 32'(stall_count), 0);
    chk("reset_timeout", 32'(mem_timeout), 0);
    reset = 1'b0;
    stall_exp = 0;

    // RUN-state priority table
    for (int i = 0; i < 12; i++) begin
      id_rs1_addr = vecs[i].rs1; id_rs2_addr = vecs[i].rs2; ex_rd_addr = vecs[i].rd;
      id_uses_rs1 = vecs[i].u1;  id_uses_rs2 = vecs[i].u2;  ex_mem_read = vecs[i].mrd;
      ex_branch_taken = vecs[i].br; mem_req = vecs[i].mreq; mem_ready = vecs[i].mrdy;
      id_halt = 1'b0;
      #1;
      chk(vecs[i].name, 32'(ctrl_now()), 32'(vecs[i].exp));
      if (vecs[i].exp[6] == 1'b0) stall_exp++;
      tick();
      chk({vecs[i].name, "_stall"}, 32'(stall_count), 32'(stall_exp));
    end

    // five-cycle memory wait then ready
    idle_inputs();
    mem_req = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("mw5_freeze", 32'(ctrl_now()), 32'(C_FRZ));
      stall_exp++;
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("mw5_advance", 32'(ctrl_now()), 32'(C_ALL));
    chk("mw5_stall", 32'(stall_count), 32'(stall_exp));
    chk("mw5_no_timeout", 32'(mem_timeout), 0);
    tick();

    // memory timeout after 64 wait cycles
    do_reset();
    mem_req = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (i == 62) begin
        chk("to_not_yet_halted", 32'(halted), 0);
        chk("to_not_yet_flag", 32'(mem_timeout), 0);
      end
    end
    chk("to_halted", 32'(halted), 1);
    chk("to_flag", 32'(mem_timeout), 1);
    chk("to_stall", 32'(stall_count), 63);
    mem_ready = 1'b1;
    tick();
    chk("to_stuck_ctrl", 32'(ctrl_now()), 32'(C_FRZ));
    chk("to_stuck_halted", 32'(halted), 1);

    // HALT drain with a branch and load-use ignored during DRAIN
    do_reset();
    id_halt = 1'b1;
    #1;
    chk("halt_entry", 32'(ctrl_now()), 32'(C_HALT));
    tick();
    id_halt = 1'b0;
    ex_branch_taken = 1'b1;
    ex_mem_read = 1'b1; ex_rd_addr = 3'd2; id_uses_rs1 = 1'b1; id_rs1_addr = 3'd2;
    #1;
    chk("drain1", 32'(ctrl_now()), 32'(C_DRAIN));
    tick();
    idle_inputs();
    #1;
    chk("drain2", 32'(ctrl_now()), 32'(C_DRAIN));
    tick();
    chk("drain2_halted", 32'(halted), 0);
    chk("drain3", 32'(ctrl_now()), 32'(C_DRAIN));
    tick();
    chk("drain_done_halted", 32'(halted), 1);
    chk("drain_done_ctrl", 32'(ctrl_now()), 32'(C_FRZ));
    chk("drain_stall", 32'(stall_count), 3);
    chk("drain_no_timeout", 32'(mem_timeout), 0);

    // memwait inside DRAIN does not count, then reset mid-DRAIN
    do_reset();
    id_halt = 1'b1;
    tick();
    id_halt = 1'b0;
    tick();
    mem_req = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("drain_memwait", 32'(ctrl_now()), 32'(C_FRZ));
    tick();
    idle_inputs();
    tick();
    chk("drain_mw_not_halted", 32'(halted), 0);
    chk("drain_mw_ctrl", 32'(ctrl_now()), 32'(C_DRAIN));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midreset_halted", 32'(halted), 0);
    chk("midreset_stall", 32'(stall_count), 0);
    chk("midreset_run", 32'(ctrl_now()), 32'(C_ALL));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
